// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive buffer.
// Defaults for data width, FIFO depth, almost-full level and counter width.
package uart_rx_fifo_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int FIFO_DEPTH_LOG2 = 4;
   localparam int FIFO_AFULL_LVL  = 12;
   localparam int ERR_CNT_W       = 8;

endpackage

// File: rtl/uart_rx_fifo_sat_cntr.sv
// Saturating event counter with synchronous clear.
// A clear coinciding with an event leaves the count at one.
module uart_rx_fifo_sat_cntr
   import uart_rx_fifo_pkg::*;
#(
   parameter int CNT_W = ERR_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // next count: clear wins, otherwise increment until all-ones
   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = CNT_W'(i_inc);
      end else if (i_inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver.
// Tracks occupancy, almost-full, overrun events and framing errors.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W     = UART_DATA_W,
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
   parameter int AFULL_LVL  = FIFO_AFULL_LVL,
   parameter int CNT_W      = ERR_CNT_W
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_err,
   output logic [DATA_W-1:0]     o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DEPTH_LOG2:0]   o_count,
   output logic                  o_afull,
   output logic [CNT_W-1:0]      o_ovr_cnt,
   output logic [CNT_W-1:0]      o_ferr_cnt,
   input  logic                  i_clr_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_q, count_d;
   logic          ready_q, ready_d;
   logic          afull_q, afull_d;
   logic          stall_q, stall_d;
   logic          empty;
   logic          push;
   logic          pop;
   logic          ovr_inc;

   // handshakes, pointer advance and next-cycle flags
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      push     = i_valid & ready_q;
      pop      = ~empty & i_ready;
      stall_d  = i_valid & ~ready_q;
      ovr_inc  = stall_d & ~stall_q;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = wr_ptr_d - rd_ptr_d;
      ready_d  = ~((wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                   (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]));
      afull_d  = (count_d >= PW'(AFULL_LVL));
   end

   // pointer and status registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
         afull_q  <= 1'b0;
         stall_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         afull_q  <= afull_d;
         stall_q  <= stall_d;
      end
   end

   // storage is left unreset; only written on an accepted push
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr_q[PW-2:0]] <= i_data;
      end
   end

   assign o_data  = mem[rd_ptr_q[PW-2:0]];
   assign o_valid = ~empty;
   assign o_ready = ready_q;
   assign o_count = count_q;
   assign o_afull = afull_q;

   uart_rx_fifo_sat_cntr #(.CNT_W(CNT_W)) u_ovr_cntr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (ovr_inc),
      .i_clr   (i_clr_cnt),
      .o_count (o_ovr_cnt)
   );

   uart_rx_fifo_sat_cntr #(.CNT_W(CNT_W)) u_ferr_cntr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (i_err),
      .i_clr   (i_clr_cnt),
      .o_count (o_ferr_cnt)
   );

endmodule
